poliriscv_loader: RTL
=====================

POLIRISCV_LOADER -- requirements
Module: poliriscv_loader

Interface
REQ-001 SHALL have parameter: instructions, 256, instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter: ADDR_W, 8, imem word-address width (clog2(instructions)).
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: rx_valid  input  1  upstream byte valid.
REQ-006 SHALL have port: rx_data  input  8  upstream byte.
REQ-007 SHALL have port: rx_ready  output  1  loader accepts byte; transfer when rx_valid && rx_ready at a rising edge.
REQ-008 SHALL have port: imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 SHALL have port: imem_addr  output  ADDR_W  word address of the write.
REQ-010 SHALL have port: imem_wdata  output  32  instruction word to write.
REQ-011 SHALL have port: core_rst  output  1  reset to poliriscv_sc core, active-high.
REQ-012 SHALL have port: done  output  1  program loaded and verified.
REQ-013 SHALL have port: error  output  1  load failed.

Function
REQ-014 SHALL accept the byte stream: N low byte, N high byte (16-bit word count), then 4*N payload bytes, then 1 checksum byte.
REQ-015 SHALL use states HDR0, HDR1, DATA, CSUM, RUN, ERR; each state advances only on an accepted byte, except RUN and ERR, which are terminal.
REQ-016 SHALL drive rx_ready = 1 in HDR0, HDR1, DATA and CSUM, and 0 in RUN and ERR.
REQ-017 SHALL ignore rx_data and rx_valid in RUN and ERR.
REQ-018 SHALL, on the HDR1 byte, go to ERR if N == 0 or N > instructions; otherwise it SHALL go to DATA with the word index cleared to 0.
REQ-019 SHALL assemble payload words little-endian: first byte goes to bits [7:0], fourth byte to bits [31:24].
REQ-020 SHALL, in the cycle after the fourth byte of a word is accepted, assert imem_we for exactly 1 cycle with imem_addr = word index and imem_wdata = assembled word.
REQ-021 SHALL increment the word index after each word is written.
REQ-022 SHALL hold imem_we = 0 in every other cycle.
REQ-023 SHALL leave imem_addr and imem_wdata unchanged when imem_we = 0.
REQ-024 SHALL transition DATA -> CSUM on acceptance of the fourth byte of word N-1.
REQ-025 SHALL maintain an 8-bit running XOR of all payload bytes only; header bytes SHALL be excluded.
REQ-026 SHALL, on the CSUM byte, go to RUN if the byte equals the running XOR, else go to ERR.
REQ-027 SHALL, on entry to RUN, set core_rst = 0 and done = 1, registered, in the cycle after the CSUM byte is accepted.
REQ-028 SHALL not issue the final imem write and the RUN entry in the same cycle in a way that releases core_rst before the last imem_we (the last write always precedes the CSUM byte).
REQ-029 SHALL, in ERR, hold error = 1, core_rst = 1 and done = 0.
REQ-030 SHALL make RUN and ERR sticky until rst.
REQ-031 SHALL tolerate arbitrary rx_valid gaps between bytes with no change in result.

Reset
REQ-032 SHALL on rst assertion immediately (asynchronously) force: state HDR0, word index 0, byte count 0, XOR 0, imem_we 0, imem_addr 0, imem_wdata 0, core_rst 1, done 0, error 0.
REQ-033 SHALL have rx_ready = 1 after reset release.
REQ-034 SHALL abort a load in progress when rst asserts mid-load; after release, the next byte SHALL be treated as HDR0, and words already written SHALL not be rewritten or erased.

Verification
REQ-035 SHALL be verified by nominal load: bytes 02 00 13 00 A0 00 93 00 50 00 70 -> imem writes addr0=0x00A00013, addr1=0x00500093; core_rst falls and done=1 one cycle after the 0x70 byte is accepted; error=0.
REQ-036 SHALL be verified by bad checksum: same stream with final byte 0x71 -> both imem writes occur, then error=1, core_rst stays 1, done=0, rx_ready=0.
REQ-037 SHALL be verified by zero count: bytes 00 00 -> ERR after second byte, no imem_we ever.
REQ-038 SHALL be verified by overflow count: bytes 01 01 (N=257, instructions=256) -> ERR after second byte, no imem_we.
REQ-039 SHALL be verified by valid gaps: nominal stream with 0-3 random idle cycles between bytes -> identical writes and done=1.
REQ-040 SHALL be verified by reset mid-load: rst pulse after 6th byte of nominal stream -> outputs at reset values, then full nominal stream -> completes as in REQ-035.

Source files
------------

// File: rtl/poliriscv_loader.sv
// Byte-stream program loader for the poliriscv_sc core.
// Fills instruction memory, checks an XOR checksum, then releases core reset.
module poliriscv_loader #(
  parameter int instructions = 256,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    HDR0, HDR1, DATA, CSUM, RUN, ERR
  } state_t;

  state_t      state, state_n;
  logic [7:0]  n_lo;
  logic [15:0] n_words;
  logic [15:0] widx;
  logic [1:0]  bcnt;
  logic [23:0] wbuf;
  logic [7:0]  csum;

  logic        acc;
  logic [15:0] n_full;
  logic        n_bad;
  logic        last_word;

  assign rx_ready  = (state == HDR0) || (state == HDR1) ||
                     (state == DATA) || (state == CSUM);
  assign acc       = rx_valid && rx_ready;
  assign n_full    = {rx_data, n_lo};
  assign n_bad     = (n_full == 16'd0) ||
                     ({1'b0, n_full} > 17'(instructions));
  assign last_word = (widx == n_words - 16'd1);

  assign core_rst  = (state != RUN);
  assign done      = (state == RUN);
  assign error     = (state == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HDR0;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (acc) begin
      unique case (state)
        HDR0: state_n = HDR1;
        HDR1: state_n = n_bad ? ERR : DATA;
        DATA: begin
          if (bcnt == 2'd3 && last_word)
            state_n = CSUM;
        end
        CSUM: state_n = (rx_data == csum) ? RUN : ERR;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lo       <= '0;
      n_words    <= '0;
      widx       <= '0;
      bcnt       <= '0;
      wbuf       <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (acc) begin
        unique case (state)
          HDR0: n_lo <= rx_data;
          HDR1: begin
            n_words <= n_full;
            widx    <= '0;
            bcnt    <= '0;
          end
          DATA: begin
            csum <= csum ^ rx_data;
            bcnt <= bcnt + 2'd1;
            unique case (bcnt)
              2'd0: wbuf[7:0]   <= rx_data;
              2'd1: wbuf[15:8]  <= rx_data;
              2'd2: wbuf[23:16] <= rx_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= widx[ADDR_W-1:0];
                imem_wdata <= {rx_data, wbuf};
                widx       <= widx + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
